seven_seg_scanner: RTL and testbench

// - Consumer end of the display_and_drop output interface.
// - Takes the four static 7-segment codes and drop_activated, and time-multiplexes them onto
//   one physical 4-digit common-anode display.
// - Sits between the drop/display logic and the board pins.
// - Snapshots all codes once per frame so a frame never tears.

---
 rtl/seven_seg_scanner.sv | 194 +++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexes four static 7-segment codes onto one 4-digit
// common-anode display. All four codes (and the drop flag) are snapshotted
// once per frame, at the start of digit 0's slot, so a frame never mixes
// old and new codes.
//
// Each digit slot lasts SCAN_DIV clocks. The first BLANK_CYC clocks of a
// slot drive every anode off so that segment data for the next digit does
// not ghost onto the previous one.
//
// Optional feature macro: DROP_BLINK_EN
//   defined   : while the snapshotted drop flag is 1, the display blinks
//               (BLINK_FRAMES frames on, BLINK_FRAMES frames off).
//   undefined : drop_activated is ignored and the display is always shown.
//
// Ports
//   clk             in   1  system clock, rising edge
//   rst_n           in   1  asynchronous assert, active-low reset
//   seven_seg1..4   in   7  digit 0..3 codes, active-high, bit0=a .. bit6=g
//   drop_activated  in   1  drop status (only used with DROP_BLINK_EN)
//   seg_n           out  7  segment cathodes, active-low
//   an_n            out  4  anodes, active-low, an_n[i] selects digit i
//   frame_done      out  1  one-cycle pulse in the first cycle of each frame
//
// All outputs come straight from flops. The output flops are loaded from
// the next-state values of the counter/index/shadow registers, so the
// output seen in slot cycle k corresponds to cnt==k.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 64,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seven_seg1,
  input  logic [6:0] seven_seg2,
  input  logic [6:0] seven_seg3,
  input  logic [6:0] seven_seg4,
  input  logic       drop_activated,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Per-slot FSM: BLANK for the leading ghost-suppression cycles, SHOW after.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [0:0]       state_q, state_d;
  logic [3:0][6:0]  shadow_q, shadow_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       an_n_q, an_n_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic             snap;
  logic             blank_slot;
  logic             hide_d;

  // Snapshot cycle: first cycle of digit 0's slot (also the first cycle
  // after reset release).
  assign snap = (idx_q == 2'd0) && (cnt_q == '0);

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Blank window is evaluated on the next counter value because the
  // output flops are loaded one cycle ahead of the slot cycle they serve.
  if (BLANK_CYC > 0) begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    assign blank_slot = (cnt_d < BLANK_LIM);
  end else begin : g_noblank
    assign blank_slot = 1'b0;
  end

  always_comb begin
    state_d = blank_slot ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d = {seven_seg4, seven_seg3, seven_seg2, seven_seg1};
    end
  end

  assign frame_done_d = (idx_q == 2'd3) && (cnt_q == CNT_MAX);

`ifdef DROP_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic          drop_q, drop_d;
  logic          phase_q, phase_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // frame_done_q is high exactly in the snapshot cycle, so counting frames
  // and latching the drop flag happen on the same edge. A frame whose
  // snapshot sees drop=0 restarts the blink sequence from scratch.
  always_comb begin
    drop_d  = drop_q;
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    if (snap) begin
      drop_d = drop_activated;
      if (!drop_activated) begin
        phase_d = 1'b0;
        fcnt_d  = '0;
      end else if (frame_done_q) begin
        if (fcnt_q == FCNT_MAX) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end
  end

  assign hide_d = phase_d & drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q  <= 1'b0;
      phase_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      drop_q  <= drop_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
    end
  end
`else
  localparam int unsigned UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic unused_drop;
  assign unused_drop = drop_activated;
  assign hide_d      = 1'b0;
`endif

  // Output decode from next-state values.
  always_comb begin
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    if ((state_d == ST_SHOW) && !hide_d) begin
      an_n_d  = ~(4'b0001 << idx_d);
      seg_n_d = ~shadow_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      an_n_q       <= 4'hF;
      seg_n_q      <= 7'h7F;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
    end
  end

  // state_q mirrors the slot phase that the output flops currently show;
  // it is kept as a named register for probing.
  logic unused_state;
  assign unused_state = state_q[0];

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Two instances share clock, reset and inputs: one with a 2-cycle blank
// window and one with none. Expected outputs are computed from absolute
// cycle number since reset release (frame / slot / slot cycle) and the
// codes the bench itself presented in each frame's snapshot cycle.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;
`ifdef DROP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] s1, s2, s3, s4;
  logic       drop;
  logic [6:0] seg_n, seg_n_nb;
  logic [3:0] an_n, an_n_nb;
  logic       frame_done, frame_done_nb;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .seven_seg1(s1), .seven_seg2(s2), .seven_seg3(s3), .seven_seg4(s4),
    .drop_activated(drop),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  seven_seg_scanner #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(0), .BLINK_FRAMES(BLINK_FRAMES)
  ) u_dut_nb (
    .clk(clk), .rst_n(rst_n),
    .seven_seg1(s1), .seven_seg2(s2), .seven_seg3(s3), .seven_seg4(s4),
    .drop_activated(drop),
    .seg_n(seg_n_nb), .an_n(an_n_nb), .frame_done(frame_done_nb)
  );

  // ---------------- model state ----------------
  int         checks = 0;
  int         failures = 0;
  int         t;
  int         rnd_level;
  logic [6:0] cur [4];
  logic [6:0] snap [4];
  logic       cur_drop;
  logic       snap_drop;
  int         blink_idx;   // frames since the drop flag was last seen low

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    s1   = cur[0];
    s2   = cur[1];
    s3   = cur[2];
    s4   = cur[3];
    drop = cur_drop;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) snap[i] = 7'h00;
    snap_drop = 1'b0;
    blink_idx = 0;
  endtask

  function automatic logic model_hide();
    return BLINK_ON && snap_drop && (((blink_idx / BLINK_FRAMES) % 2) == 1);
  endfunction

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (an_n === 4'hF) else begin
      failures++; $error("FAIL %s an_n got=%b exp=1111", tag, an_n);
    end
    checks++;
    assert (seg_n === 7'h7F) else begin
      failures++; $error("FAIL %s seg_n got=%h exp=7f", tag, seg_n);
    end
    checks++;
    assert (frame_done === 1'b0) else begin
      failures++; $error("FAIL %s frame_done got=%b exp=0", tag, frame_done);
    end
    checks++;
    assert (an_n_nb === 4'hF) else begin
      failures++; $error("FAIL %s an_n_nb got=%b exp=1111", tag, an_n_nb);
    end
    checks++;
    assert (seg_n_nb === 7'h7F) else begin
      failures++; $error("FAIL %s seg_n_nb got=%h exp=7f", tag, seg_n_nb);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_cycle();
    int         k;
    int         slot;
    logic       hide;
    logic [3:0] ea, ea_nb;
    logic [6:0] es, es_nb;
    logic       efd;
    k     = t % SCAN_DIV;
    slot  = (t % FRAME) / SCAN_DIV;
    hide  = model_hide();
    ea    = 4'hF;
    es    = 7'h7F;
    ea_nb = 4'hF;
    es_nb = 7'h7F;
    if (k >= BLANK_CYC && !hide) begin
      ea = ~(4'b0001 << slot);
      es = ~snap[slot];
    end
    if (t > 0 && !hide) begin
      ea_nb = ~(4'b0001 << slot);
      es_nb = ~snap[slot];
    end
    efd = ((t % FRAME) == 0) && (t > 0);

    checks++;
    assert (an_n === ea) else begin
      failures++; $error("FAIL an_n t=%0d got=%b exp=%b", t, an_n, ea);
    end
    checks++;
    assert (seg_n === es) else begin
      failures++; $error("FAIL seg_n t=%0d got=%h exp=%h", t, seg_n, es);
    end
    checks++;
    assert (frame_done === efd) else begin
      failures++; $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, efd);
    end
    checks++;
    assert (an_n_nb === ea_nb) else begin
      failures++; $error("FAIL an_n_nb t=%0d got=%b exp=%b", t, an_n_nb, ea_nb);
    end
    checks++;
    assert (seg_n_nb === es_nb) else begin
      failures++; $error("FAIL seg_n_nb t=%0d got=%h exp=%h", t, seg_n_nb, es_nb);
    end
    checks++;
    assert (frame_done_nb === efd) else begin
      failures++; $error("FAIL frame_done_nb t=%0d got=%b exp=%b", t, frame_done_nb, efd);
    end
  endtask

  // Input changes for the current cycle, then the model's snapshot.
  task automatic stim_and_snapshot();
    if (t == 18) begin
      cur[1] = 7'h50;
    end else if (rnd_level > 0 && t > FRAME) begin
      if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, 3)] = 7'($urandom_range(0, 127));
      if (rnd_level > 1 && $urandom_range(0, 15) == 0) cur_drop = ~cur_drop;
    end
    drive_inputs();
    if ((t % FRAME) == 0) begin
      for (int i = 0; i < 4; i++) snap[i] = cur[i];
      blink_idx = (t == 0 || !cur_drop) ? 0 : blink_idx + 1;
      snap_drop = cur_drop;
    end
  endtask

  task automatic run_until(input int target);
    while (t < target) begin
      check_cycle();
      stim_and_snapshot();
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b1;
    cur_drop  = 1'b0;
    rnd_level = 0;
    t         = 0;
    for (int i = 0; i < 4; i++) cur[i] = 7'h00;
    drive_inputs();
    model_reset();

    // Asynchronous reset with no clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");

    cur[0] = 7'h39; cur[1] = 7'h5C; cur[2] = 7'h38; cur[3] = 7'h5E;
    cur_drop = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    t = 0;

    run_until(2);
    checks++;
    assert (an_n === 4'b1110 && seg_n === 7'h46) else begin
      failures++; $error("FAIL first_show got=%b/%h exp=1110/46", an_n, seg_n);
    end

    run_until(FRAME);
    checks++;
    assert (frame_done === 1'b1) else begin
      failures++; $error("FAIL frame_done_32 got=%b exp=1", frame_done);
    end

    // Digit 1 changed to 50 during frame 0, slot 2; visible from frame 1.
    run_until(FRAME + SCAN_DIV + 2);
    checks++;
    assert (an_n === 4'b1101 && seg_n === 7'h2F) else begin
      failures++; $error("FAIL next_frame_digit1 got=%b/%h exp=1101/2f", an_n, seg_n);
    end

    rnd_level = 1;
    run_until(6 * FRAME);
    rnd_level = 2;
    run_until(9 * FRAME + 2 * SCAN_DIV + 5);
    check_cycle();

    // Reset during idx==2, cnt==5.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_slot");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_held");
    model_reset();
    rst_n = 1'b1;
    t = 0;
    run_until(3 * FRAME + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
